// File: rtl/usb_audio_pkg.sv
// Shared constants for the USB audio output blocks: I2S frame geometry, NCO defaults,
// and the BCLK edge classification used by the serialiser.
package usb_audio_pkg;

    localparam int FRAME_BCLKS = 64;
    localparam int SLOT_BCLKS  = 32;
    localparam int DEF_NCO_INC = 6711;
    localparam int DEF_NCO_W   = 16;
    localparam int IDX_W       = $clog2(FRAME_BCLKS);

    typedef enum logic [1:0] {
        EDGE_NONE  = 2'd0,
        EDGE_RISE  = 2'd1,
        EDGE_FALL  = 2'd2,
        EDGE_FRAME = 2'd3
    } bclk_edge_e;

endpackage

// File: rtl/usb_audio_nco.sv
// Fractional NCO: phase accumulator whose carry-out forms a one-clock tick.
// The synchronous clear zeroes the phase and suppresses any tick in that clock.
module usb_audio_nco
    import usb_audio_pkg::*;
#(
    parameter int NCO_W   = DEF_NCO_W,
    parameter int NCO_INC = DEF_NCO_INC
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam logic [NCO_W:0] INC_EXT = (NCO_W + 1)'(NCO_INC);

    logic [NCO_W-1:0] acc_r;
    logic [NCO_W:0]   sum_s;

    // Next phase and its carry; a clear always wins over a pending carry.
    always_comb begin
        sum_s = {1'b0, acc_r} + INC_EXT;
        if (clr) begin
            tick = 1'b0;
        end else begin
            tick = sum_s[NCO_W];
        end
    end

    // Phase accumulator, wraps modulo 2^NCO_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r <= {NCO_W{1'b0}};
        end else if (clr) begin
            acc_r <= {NCO_W{1'b0}};
        end else begin
            acc_r <= sum_s[NCO_W-1:0];
        end
    end

endmodule

// File: rtl/usb_audio_i2s_tx.sv
// I2S transmitter for the 16-bit stereo USB audio stream: NCO-derived BCLK, LRCK and
// MSB-first SDATA with the one-bit I2S delay, all in the USB core clock domain.
module usb_audio_i2s_tx
    import usb_audio_pkg::*;
#(
    parameter int NCO_W   = DEF_NCO_W,
    parameter int NCO_INC = DEF_NCO_INC,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [DATA_W-1:0] audio_L_ch,
    input  logic [DATA_W-1:0] audio_R_ch,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
    output logic              frame_stb
);

    localparam int               SHIFT_W  = 2 * SLOT_BCLKS;
    localparam int               PAD_W    = SLOT_BCLKS - 1 - DATA_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BCLKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_R    = IDX_W'(SLOT_BCLKS);

    // One channel slot: delay bit, sample MSB first, zero padding.
    function automatic logic [SLOT_BCLKS-1:0] slot_word(input logic [DATA_W-1:0] sample);
        slot_word = {1'b0, sample, {PAD_W{1'b0}}};
    endfunction

    logic               clr_s;
    logic               tick_s;
    bclk_edge_e         edge_s;
    logic [IDX_W-1:0]   idx_r, idx_nxt_s, idx_inc_s;
    logic [SHIFT_W-1:0] shift_r, shift_nxt_s;
    logic               bclk_r, bclk_nxt_s;
    logic               lrck_r, lrck_nxt_s;
    logic               sdata_r, sdata_nxt_s;
    logic               stb_r, stb_nxt_s;

    assign clr_s = ~en;

    usb_audio_nco #(
        .NCO_W   (NCO_W),
        .NCO_INC (NCO_INC)
    ) u_nco (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Classify the current tick as a BCLK rise, an ordinary fall or the frame-start fall.
    always_comb begin
        idx_inc_s = idx_r + IDX_ONE;
        if (!tick_s) begin
            edge_s = EDGE_NONE;
        end else if (!bclk_r) begin
            edge_s = EDGE_RISE;
        end else if (idx_r == IDX_LAST) begin
            edge_s = EDGE_FRAME;
        end else begin
            edge_s = EDGE_FALL;
        end
    end

    // Next state: only falling edges move data; the L/R pair is captured whole at frame start.
    always_comb begin
        bclk_nxt_s  = bclk_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        lrck_nxt_s  = lrck_r;
        sdata_nxt_s = sdata_r;
        stb_nxt_s   = 1'b0;
        case (edge_s)
            EDGE_RISE: begin
                bclk_nxt_s = 1'b1;
            end
            EDGE_FALL: begin
                bclk_nxt_s  = 1'b0;
                idx_nxt_s   = idx_inc_s;
                shift_nxt_s = {shift_r[SHIFT_W-2:0], 1'b0};
                sdata_nxt_s = shift_r[SHIFT_W-2];
                lrck_nxt_s  = (idx_inc_s >= IDX_R);
            end
            EDGE_FRAME: begin
                bclk_nxt_s  = 1'b0;
                idx_nxt_s   = {IDX_W{1'b0}};
                shift_nxt_s = {slot_word(audio_L_ch), slot_word(audio_R_ch)};
                sdata_nxt_s = 1'b0;
                lrck_nxt_s  = 1'b0;
                stb_nxt_s   = 1'b1;
            end
            default: begin
                bclk_nxt_s = bclk_r;
            end
        endcase
        // A stop discards any tick in the same clock and parks the frame before its start.
        if (!en) begin
            bclk_nxt_s  = 1'b0;
            idx_nxt_s   = IDX_LAST;
            shift_nxt_s = {SHIFT_W{1'b0}};
            lrck_nxt_s  = 1'b0;
            sdata_nxt_s = 1'b0;
            stb_nxt_s   = 1'b0;
        end else begin
            stb_nxt_s = stb_nxt_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bclk_r  <= 1'b0;
            idx_r   <= IDX_LAST;
            shift_r <= {SHIFT_W{1'b0}};
            lrck_r  <= 1'b0;
            sdata_r <= 1'b0;
            stb_r   <= 1'b0;
        end else begin
            bclk_r  <= bclk_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            lrck_r  <= lrck_nxt_s;
            sdata_r <= sdata_nxt_s;
            stb_r   <= stb_nxt_s;
        end
    end

    assign i2s_bclk  = bclk_r;
    assign i2s_lrck  = lrck_r;
    assign i2s_sdata = sdata_r;
    assign frame_stb = stb_r;

endmodule

// File: tb/tb_usb_audio_i2s_tx.sv
// Self-checking bench for usb_audio_i2s_tx: a frame-level model decodes SDATA/LRCK at
// every BCLK edge while a directed sequence exercises data, rate, stop and reset cases.
`timescale 1ns/1ps
module tb_usb_audio_i2s_tx;

    localparam int NCO_W   = 16;
    localparam int NCO_INC = 6711;
    localparam int DATA_W  = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic [DATA_W-1:0] audio_l;
    logic [DATA_W-1:0] audio_r;
    logic              i2s_bclk;
    logic              i2s_lrck;
    logic              i2s_sdata;
    logic              frame_stb;

    int checks   = 0;
    int failures = 0;

    always #8 clk = ~clk;

    usb_audio_i2s_tx #(
        .NCO_W   (NCO_W),
        .NCO_INC (NCO_INC),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .audio_L_ch (audio_l),
        .audio_R_ch (audio_r),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_sdata  (i2s_sdata),
        .frame_stb  (frame_stb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Expected SDATA for bit position p of a frame carrying (l, r).
    function automatic logic exp_bit(input int p, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        if (p >= 1 && p <= DATA_W)
            return l[DATA_W - p];
        else if (p >= 33 && p <= 32 + DATA_W)
            return r[32 + DATA_W - p];
        else
            return 1'b0;
    endfunction

    // Frame model state
    bit                mon_on = 1'b0;
    bit                in_frame = 1'b0;
    bit                phase_ok = 1'b0;
    int                pos = 0;
    int                phase_cnt = 0;
    int                rises = 0;
    int                frames = 0;
    int                frames_done = 0;
    logic [DATA_W-1:0] cur_l, cur_r, dec_l, dec_r, last_l, last_r, l_prev, r_prev;
    logic              bclk_p = 1'b0;
    logic              lrck_p = 1'b0;

    // Monitor sampling on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        bit fall, rise;
        if (!rstn || !en || !mon_on) begin
            in_frame  = 1'b0;
            phase_ok  = 1'b0;
            phase_cnt = 0;
            pos       = 0;
        end else begin
            fall = bclk_p && !i2s_bclk;
            rise = !bclk_p && i2s_bclk;
            if (i2s_bclk != bclk_p) begin
                if (phase_ok) check_range("bclk_phase", phase_cnt, 9, 10);
                phase_ok  = 1'b1;
                phase_cnt = 1;
            end else begin
                phase_cnt++;
            end
            if (i2s_lrck != lrck_p) check("lrck_on_fall", fall, 1'b1);
            if (frame_stb) begin
                check("stb_on_fall", fall, 1'b1);
                if (in_frame) check("stb_pos", pos, 63);
                if (in_frame && pos == 63) begin
                    last_l = dec_l;
                    last_r = dec_r;
                    frames_done++;
                end
                in_frame = 1'b1;
                pos      = 0;
                cur_l    = l_prev;
                cur_r    = r_prev;
                frames++;
            end else if (fall) begin
                check("stb_missing", (in_frame && pos != 63), 1'b1);
                pos++;
            end
            if (rise) begin
                rises++;
                if (in_frame) begin
                    check("sdata_bit", i2s_sdata, exp_bit(pos, cur_l, cur_r));
                    check("lrck_lvl", i2s_lrck, (pos >= 32));
                    if (pos >= 1 && pos <= DATA_W) dec_l = {dec_l[DATA_W-2:0], i2s_sdata};
                    if (pos >= 33 && pos <= 32 + DATA_W) dec_r = {dec_r[DATA_W-2:0], i2s_sdata};
                end
            end
        end
        bclk_p = i2s_bclk;
        lrck_p = i2s_lrck;
        l_prev = audio_l;
        r_prev = audio_r;
    end

    task automatic wait_done(input int n, input int budget);
        int target;
        int c;
        target = frames_done + n;
        c = 0;
        while (frames_done < target && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        check("frame_timeout", (frames_done >= target), 1'b1);
    endtask

    task automatic wait_pos(input int p, input int budget);
        int c;
        c = 0;
        while (!(in_frame && pos == p) && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        check("pos_timeout", (in_frame && pos == p), 1'b1);
    endtask

    // Clean-start checks: frame start on the second NCO carry, preceded by exactly one rise.
    task automatic restart_checks(input string tag, input logic [DATA_W-1:0] new_l, input int r0);
        int n;
        int exp_lat;
        exp_lat = (2 * (1 << NCO_W) + NCO_INC - 1) / NCO_INC;
        n = 0;
        while (!frame_stb && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        #2;
        check({tag, "_rises"}, rises - r0, 1);
        wait_done(1, 3000);
        check({tag, "_first_l"}, last_l, new_l);
    endtask

    initial begin
        longint ticks;
        int r0, f0;
        logic [DATA_W-1:0] new_l;

        rstn = 1'b0; en = 1'b0; audio_l = '0; audio_r = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_bclk", i2s_bclk, 1'b0);
        check("rst_lrck", i2s_lrck, 1'b0);
        check("rst_sdata", i2s_sdata, 1'b0);
        check("rst_stb", frame_stb, 1'b0);

        // Scenario 1: fixed pattern
        audio_l = 16'hA5C3; audio_r = 16'h3C5A;
        rstn = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("idle_bclk", i2s_bclk, 1'b0);
        en = 1'b1; mon_on = 1'b1;
        wait_done(1, 3000);
        check("s1_left", last_l, 16'hA5C3);
        check("s1_right", last_r, 16'h3C5A);

        // Randomised sample changes at arbitrary points in the frame
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(900, 40)) @(posedge clk);
            #2;
            audio_l = 16'($urandom);
            audio_r = 16'($urandom);
            wait_done(1, 3000);
        end

        // Scenario 4: mid-frame change is deferred to the next frame
        audio_l = 16'h1111; audio_r = 16'($urandom);
        f0 = frames;
        while (frames == f0) begin @(posedge clk); #2; end
        wait_pos(20, 2000);
        audio_l = 16'h2222;
        wait_done(1, 3000);
        check("s4_old_l", last_l, 16'h1111);
        wait_done(1, 3000);
        check("s4_new_l", last_l, 16'h2222);

        // Scenario 5: stop in the right slot, then clean restart
        wait_pos(40, 3000);
        check("s5_lrck_pre", i2s_lrck, 1'b1);
        en = 1'b0;
        @(posedge clk); #1;
        check("s5_bclk", i2s_bclk, 1'b0);
        check("s5_lrck", i2s_lrck, 1'b0);
        check("s5_sdata", i2s_sdata, 1'b0);
        check("s5_stb", frame_stb, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        check("s5_hold_bclk", i2s_bclk, 1'b0);
        new_l = 16'($urandom);
        audio_l = new_l;
        en = 1'b1;
        r0 = rises;
        restart_checks("s5", new_l, r0);

        // Scenario 6: asynchronous reset pulse mid right slot
        wait_pos(40, 3000);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check("s6_bclk", i2s_bclk, 1'b0);
        check("s6_lrck", i2s_lrck, 1'b0);
        check("s6_sdata", i2s_sdata, 1'b0);
        check("s6_stb", frame_stb, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        new_l = 16'($urandom);
        audio_l = new_l;
        rstn = 1'b1;
        r0 = rises;
        restart_checks("s6", new_l, r0);

        // Scenario 2 (scaled window): rates against the NCO carry count
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        en = 1'b1;
        r0 = rises; f0 = frames;
        repeat (30000) @(posedge clk);
        #2;
        ticks = (longint'(30000) * NCO_INC) >> NCO_W;
        check_range("rate_rises", rises - r0, (ticks + 1) / 2 - 1, (ticks + 1) / 2 + 1);
        check_range("rate_frames", frames - f0, (ticks / 2 + 63) / 64 - 1, (ticks / 2 + 63) / 64 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
